// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction/state types and the heading-reversal helper for the snake tracker
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_L,
        DIR_R,
        DIR_U,
        DIR_D
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_OVER
    } state_t;

    function automatic logic is_opposite(dir_t a, dir_t b);
        logic opp;
        case (a)
            DIR_L:   opp = (b == DIR_R);
            DIR_R:   opp = (b == DIR_L);
            DIR_U:   opp = (b == DIR_D);
            default: opp = (b == DIR_U);
        endcase
        return opp;
    endfunction

endpackage

// File: rtl/snake_next_cell.sv
// rtl/snake_next_cell.sv - combinational neighbour-cell calculator with wrap or solid-wall edges
module snake_next_cell
    import snake_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int WRAP = 1
) (
    input  logic [$clog2(ROWS)-1:0] row,
    input  logic [$clog2(COLS)-1:0] col,
    input  dir_t                    dir,
    output logic [$clog2(ROWS)-1:0] next_row,
    output logic [$clog2(COLS)-1:0] next_col,
    output logic                    off_grid
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    // On a wall hit the indices stay on the current cell so downstream lookups remain in range.
    always_comb begin
        next_row = row;
        next_col = col;
        off_grid = 1'b0;
        case (dir)
            DIR_L: begin
                if (col == COL_MAX) begin
                    if (WRAP != 0) next_col = '0;
                    else           off_grid = 1'b1;
                end else begin
                    next_col = col + CW'(1);
                end
            end
            DIR_R: begin
                if (col == '0) begin
                    if (WRAP != 0) next_col = COL_MAX;
                    else           off_grid = 1'b1;
                end else begin
                    next_col = col - CW'(1);
                end
            end
            DIR_U: begin
                if (row == ROW_MAX) begin
                    if (WRAP != 0) next_row = '0;
                    else           off_grid = 1'b1;
                end else begin
                    next_row = row + RW'(1);
                end
            end
            default: begin
                if (row == '0) begin
                    if (WRAP != 0) next_row = ROW_MAX;
                    else           off_grid = 1'b1;
                end else begin
                    next_row = row - RW'(1);
                end
            end
        endcase
    end

endmodule

// File: rtl/snake_head_tracker.sv
// rtl/snake_head_tracker.sv - snake head position, heading register, collision detection and game-state FSM
module snake_head_tracker
    import snake_pkg::*;
#(
    parameter int   ROWS     = 8,
    parameter int   COLS     = 8,
    parameter int   WRAP     = 1,
    parameter int   INIT_ROW = 3,
    parameter int   INIT_COL = 5,
    parameter dir_t INIT_DIR = DIR_L,
    parameter int   STEP_W   = 16
) (
    input  logic                        Clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        tick,
    input  logic                        L,
    input  logic                        R,
    input  logic                        U,
    input  logic                        D,
    input  logic [ROWS-1:0][COLS-1:0]   green_array,
    input  logic [ROWS-1:0][COLS-1:0]   score_array,
    output logic [ROWS-1:0][COLS-1:0]   head_position,
    output logic [$clog2(ROWS)-1:0]     head_row,
    output logic [$clog2(COLS)-1:0]     head_col,
    output dir_t                        heading,
    output logic                        hit_score,
    output logic                        hit_own_body,
    output logic                        hit_wall,
    output logic                        gameover,
    output state_t                      state,
    output logic [STEP_W-1:0]           steps
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] INIT_R = RW'(INIT_ROW);
    localparam logic [CW-1:0] INIT_C = CW'(INIT_COL);

    state_t          state_nxt;
    dir_t            req_dir;
    dir_t            eff_dir;
    logic            req_any;
    logic            accepted;
    logic [RW-1:0]   nxt_row;
    logic [CW-1:0]   nxt_col;
    logic            off_grid;
    logic            run_tick;
    logic            wall_hit;
    logic            body_hit;
    logic            restart;

    // Fixed priority L>R>U>D picks one request first; only then is it checked against reversal.
    always_comb begin
        req_any = L | R | U | D;
        if (L)      req_dir = DIR_L;
        else if (R) req_dir = DIR_R;
        else if (U) req_dir = DIR_U;
        else        req_dir = DIR_D;
        accepted = req_any && (state != ST_OVER) && !is_opposite(req_dir, heading);
        eff_dir  = accepted ? req_dir : heading;
    end

    snake_next_cell #(
        .ROWS (ROWS),
        .COLS (COLS),
        .WRAP (WRAP)
    ) u_next_cell (
        .row      (head_row),
        .col      (head_col),
        .dir      (eff_dir),
        .next_row (nxt_row),
        .next_col (nxt_col),
        .off_grid (off_grid)
    );

    always_comb begin
        run_tick = (state == ST_RUN) && tick;
        wall_hit = run_tick && off_grid;
        body_hit = run_tick && !off_grid && green_array[nxt_row][nxt_col];
        restart  = (state == ST_OVER) && start;
    end

    always_ff @(posedge Clock) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (wall_hit || body_hit) state_nxt = ST_OVER;
            ST_OVER: if (start) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        gameover = (state == ST_OVER);
    end

    always_ff @(posedge Clock) begin
        if (!reset || restart) begin
            head_row     <= INIT_R;
            head_col     <= INIT_C;
            heading      <= INIT_DIR;
            hit_score    <= 1'b0;
            hit_own_body <= 1'b0;
            hit_wall     <= 1'b0;
            steps        <= '0;
        end else begin
            hit_score <= 1'b0;
            if (accepted) heading <= req_dir;
            if (wall_hit) begin
                hit_wall <= 1'b1;
            end else if (body_hit) begin
                hit_own_body <= 1'b1;
            end else if (run_tick) begin
                head_row  <= nxt_row;
                head_col  <= nxt_col;
                hit_score <= score_array[nxt_row][nxt_col];
                if (steps != '1) steps <= steps + STEP_W'(1);
            end
        end
    end

    // Decoding the map from the indices keeps it one-hot and in step with head_row/head_col.
    always_comb begin
        head_position = '0;
        head_position[head_row][head_col] = 1'b1;
    end

endmodule
